// File: rtl/uart_pkg.sv
// Shared state encoding and 8N1 frame constants for the burst UART transmitter
// and its byte serializer.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_FIN
    } state_t;

    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_burst_if.sv
// Handshake between the burst sequencer (master) and the byte serializer (slave).
interface uart_tx_burst_if;
    import uart_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 done;
    state_t               phase_nxt;
    logic                 tx;

    modport master (output start, data, input ready, done, phase_nxt, tx);
    modport slave  (input start, data, output ready, done, phase_nxt, tx);
endinterface

// File: rtl/uart_tx_byte.sv
// Serializes one byte as an 8N1 frame: bit timing, shift register and bit count.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input logic            clk,
    input logic            rst,
    uart_tx_burst_if.slave byte_if
);
    import uart_pkg::*;

    localparam int               CNT_W       = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    state_t               phase_q, phase_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bit_end;

    assign bit_end = (baud_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_if.tx   = 1'b1;
        byte_if.done = 1'b0;
        case (phase_q)
            S_IDLE: begin
                if (byte_if.start) begin
                    shift_d = byte_if.data;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    phase_d = S_START;
                end
            end
            S_START: begin
                byte_if.tx = 1'b0;
                if (bit_end) begin
                    baud_d  = BAUD_RELOAD;
                    phase_d = S_DATA;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                byte_if.tx = shift_q[0];
                if (bit_end) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        phase_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // The baud counter is already 0 here, so a finished frame leaves counters cleared.
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d        = '0;
                        phase_d      = S_IDLE;
                        byte_if.done = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        baud_d = BAUD_RELOAD;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            default: phase_d = S_IDLE;
        endcase
        byte_if.ready     = (phase_q == S_IDLE);
        byte_if.phase_nxt = phase_d;
    end

endmodule

// File: rtl/uart_tx_burst.sv
// Sends data_length_i bytes from a byte buffer over a UART line, one read per byte,
// with a two-cycle fetch/load gap between frames.
module uart_tx_burst #(
    parameter int CLKS_PER_BIT = 868,
    parameter int LEN_W        = 10
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESET,
    input  logic [LEN_W-1:0] data_length_i,
    input  logic             sent_trig_i,
    output logic             mem_rd_en_o,
    output logic [LEN_W-1:0] mem_addr_o,
    input  logic [7:0]       mem_data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);
    import uart_pkg::*;

    uart_tx_burst_if byte_if ();

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             more_bytes;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk    (S_AXI_ACLK),
        .rst    (S_AXI_ARESET),
        .byte_if(byte_if)
    );

    assign more_bytes = (({1'b0, idx_q} + (LEN_W + 1)'(1)) < {1'b0, len_q});

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        byte_if.start = 1'b0;
        byte_if.data  = mem_data_i;
        case (state_q)
            S_IDLE: begin
                if (sent_trig_i && (data_length_i != '0)) begin
                    len_d   = data_length_i;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                byte_if.start = byte_if.ready;
                state_d       = S_START;
            end
            S_START, S_DATA, S_STOP: begin
                // Frame phases track the serializer so the sequencer state always names the bit on the line.
                if (byte_if.done) begin
                    if (more_bytes) begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_FIN;
                    end
                end else begin
                    state_d = byte_if.phase_nxt;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_rd_en_o = (state_q == S_FETCH);
    assign mem_addr_o  = idx_q;
    assign tx_o        = byte_if.tx;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FIN);

endmodule

// File: tb/tb_uart_tx_burst.sv
// Scoreboard bench for uart_tx_burst: triggers push expected reads, frames and busy
// lengths; independent monitors decode the line and pop the expectations.
module tb_uart_tx_burst;

    localparam int CPB         = 4;
    localparam int LEN_W       = 10;
    localparam int BYTE_CYCLES = 10 * CPB + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] data_length;
    logic             sent_trig;
    logic             mem_rd_en;
    logic [LEN_W-1:0] mem_addr;
    logic [7:0]       mem_data;
    logic             tx;
    logic             busy;
    logic             done;

    logic [7:0] mem [0:(1<<LEN_W)-1];
    logic [7:0] exp_bytes[$];
    int         exp_addrs[$];
    int         exp_busy[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int model_busy_until = 0;

    uart_tx_burst #(
        .CLKS_PER_BIT(CPB),
        .LEN_W       (LEN_W)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .data_length_i(data_length),
        .sent_trig_i  (sent_trig),
        .mem_rd_en_o  (mem_rd_en),
        .mem_addr_o   (mem_addr),
        .mem_data_i   (mem_data),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer data is only defined in the cycle right after a read strobe.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_data <= mem[mem_addr];
        else                    mem_data <= 'x;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // A burst is accepted only if the model says the block is idle when the trigger is sampled.
    task automatic applyStimulus(input int len);
        @(negedge clk);
        sent_trig   = 1'b1;
        data_length = LEN_W'(len);
        if (len != 0 && cyc >= model_busy_until) begin
            for (int i = 0; i < len; i++) begin
                exp_bytes.push_back(mem[i]);
                exp_addrs.push_back(i);
            end
            exp_busy.push_back(len * BYTE_CYCLES + 1);
            model_busy_until = cyc + len * BYTE_CYCLES + 2;
        end
        @(negedge clk);
        sent_trig   = 1'b0;
        data_length = LEN_W'($urandom);
    endtask

    task automatic waitIdle();
        while (cyc < model_busy_until + 1) @(negedge clk);
        checkOutput("done_seen", 32'(exp_busy.size()), 0);
        checkOutput("bytes_sent", 32'(exp_bytes.size()), 0);
        checkOutput("reads_done", 32'(exp_addrs.size()), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        exp_bytes.delete();
        exp_addrs.delete();
        exp_busy.delete();
        @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("rst_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        model_busy_until = cyc;
    endtask

    initial begin : busy_monitor
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                busy_cnt = 0;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) begin
                    if (exp_busy.size() == 0) checkOutput("unexpected_done", 1, 0);
                    else                      checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_busy.pop_front()));
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : read_monitor
        logic [LEN_W-1:0] last_addr;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                last_addr = '0;
            end else if (mem_rd_en === 1'b1) begin
                if (exp_addrs.size() == 0) checkOutput("unexpected_read", 1, 0);
                else                       checkOutput("read_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
                last_addr = mem_addr;
            end else if (mem_rd_en === 1'b0) begin
                checkOutput("addr_hold", 32'(mem_addr), 32'(last_addr));
            end
        end
    end

    // Decodes 8N1 frames from the line, checking every cycle of every bit.
    initial begin : uart_monitor
        logic [9:0] bits;
        bit         glitch;
        bit         aborted;
        bit         expect_gap;
        int         gap;
        expect_gap = 1'b0;
        gap        = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                expect_gap = 1'b0;
                gap        = 0;
            end else if (tx === 1'b0) begin
                if (expect_gap) checkOutput("byte_gap", 32'(gap), 2);
                glitch  = 1'b0;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < CPB; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst === 1'b1) aborted = 1'b1;
                        if (k == 0)              bits[b] = tx;
                        else if (tx !== bits[b]) glitch  = 1'b1;
                    end
                end
                if (!aborted) begin
                    if (exp_bytes.size() == 0) begin
                        checkOutput("unexpected_frame", 1, 0);
                    end else begin
                        checkOutput("frame_byte", 32'(bits[8:1]), 32'(exp_bytes.pop_front()));
                        checkOutput("frame_shape", 32'({glitch, bits[9], bits[0]}), 32'(3'b010));
                    end
                end
                expect_gap = !aborted && (exp_bytes.size() != 0);
                gap        = 0;
            end else begin
                gap++;
            end
        end
    end

    initial begin : watchdog
        #(90000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit quiet;
        rst         = 1'b1;
        sent_trig   = 1'b0;
        data_length = '0;
        for (int i = 0; i < (1 << LEN_W); i++) mem[i] = 8'h00;
        doReset();

        $display("[TB] single byte 0xA5");
        mem[0] = 8'hA5;
        applyStimulus(1);
        checkOutput("busy_after_trig", 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("first_start_bit", 32'(tx), 0);
        waitIdle();

        $display("[TB] three bytes 00 FF 55");
        mem[0] = 8'h00;
        mem[1] = 8'hFF;
        mem[2] = 8'h55;
        applyStimulus(3);
        waitIdle();

        $display("[TB] zero length trigger");
        applyStimulus(0);
        quiet = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || tx !== 1'b1) quiet = 1'b0;
        end
        checkOutput("len0_quiet", 32'(quiet), 1);

        $display("[TB] random bursts");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            applyStimulus(int'($urandom_range(1, 5)));
            waitIdle();
        end

        $display("[TB] back-to-back trigger in first idle cycle");
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        applyStimulus(2);
        while (cyc < model_busy_until - 1) @(negedge clk);
        applyStimulus(1);
        waitIdle();

        $display("[TB] re-trigger during first byte");
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        applyStimulus(2);
        repeat (10) @(negedge clk);
        applyStimulus(5);
        waitIdle();

        $display("[TB] reset during data bits of second byte");
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        applyStimulus(4);
        repeat (56) @(negedge clk);
        doReset();
        repeat (60) @(negedge clk);
        mem[0] = 8'($urandom);
        applyStimulus(1);
        waitIdle();

        $display("[TB] maximum length burst");
        for (int i = 0; i < (1 << LEN_W); i++) mem[i] = 8'(i);
        applyStimulus((1 << LEN_W) - 1);
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
